ps2_host_tx: RTL

Host-to-device PS/2 transmitter. It sends one command byte (for example LED set 0xED, reset 0xFF, or an LED mask) from the FPGA to the keyboard using the PS/2 host-request protocol, and checks the device's ACK bit. It drives the shared PS2_CLK/PS2_DAT lines through open-drain enables at the top level, alongside the existing PS2_Controller receive path. While `cmd_busy` is high, the receive path ignores line activity.

---
 rtl/ps2_pkg.sv | 30 +++
 rtl/ps2_host_tx_if.sv | 23 ++
 rtl/ps2_edge_sync.sv | 29 ++
 rtl/ps2_host_tx.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// PS/2 host-transmit shared types, command constants and default timing.
// Timing defaults assume a 50 MHz core clock.
package ps2_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_REQ,
    S_WAIT_CLK,
    S_XFER,
    S_DONE,
    S_ERR
  } ps2_tx_state_t;

  localparam logic [7:0] PS2_CMD_SETLED = 8'hED;
  localparam logic [7:0] PS2_CMD_RESET  = 8'hFF;
  localparam logic [7:0] PS2_ACK        = 8'hFA;
  localparam logic [7:0] PS2_BREAK      = 8'hF0;

  localparam int PS2_INHIBIT_CYCLES = 5000;
  localparam int PS2_START_TIMEOUT  = 750000;
  localparam int PS2_XFER_TIMEOUT   = 100000;
  localparam int PS2_TIMER_W        = 20;

  // {stop, odd parity, data}; shifted out LSB first.
  function automatic logic [9:0] ps2_frame(input logic [7:0] data);
    return {1'b1, ~(^data), data};
  endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Command handshake plus PS/2 pin sense/drive bundle for the host transmitter.
// slave = transmitter side, master = command issuer / pin environment.
interface ps2_host_tx_if;
  logic [7:0] cmd_data;
  logic       cmd_send;
  logic       cmd_busy;
  logic       cmd_done;
  logic       cmd_error;
  logic       ps2_clk_in;
  logic       ps2_dat_in;
  logic       ps2_clk_oe;
  logic       ps2_dat_oe;

  modport master (
    output cmd_data, cmd_send, ps2_clk_in, ps2_dat_in,
    input  cmd_busy, cmd_done, cmd_error, ps2_clk_oe, ps2_dat_oe
  );

  modport slave (
    input  cmd_data, cmd_send, ps2_clk_in, ps2_dat_in,
    output cmd_busy, cmd_done, cmd_error, ps2_clk_oe, ps2_dat_oe
  );
endinterface

// File: rtl/ps2_edge_sync.sv
// Two-flop synchronizer and one-register falling-edge detect for a PS/2 pin.
// o_sync lags the pin by 2 cycles; o_fall is valid the cycle o_sync first reads 0.
module ps2_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_sync,
  output logic o_fall
);
  logic r_meta;
  logic r_sync;
  logic r_prev;

  // Reset to the idle-high line level so reset release never looks like an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
      r_prev <= 1'b1;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_sync = r_sync;
  assign o_fall = r_prev & ~r_sync;
endmodule

// File: rtl/ps2_host_tx.sv
// Sends one byte host-to-device over PS/2 and checks the device ACK; one send at a time,
// cmd_send is ignored while busy. Pin edge to dat_oe update: 3 cycles.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = PS2_INHIBIT_CYCLES,
  parameter int START_TIMEOUT  = PS2_START_TIMEOUT,
  parameter int XFER_TIMEOUT   = PS2_XFER_TIMEOUT
) (
  input logic           CLOCK_50,
  input logic           resetn,
  ps2_host_tx_if.slave  bus
);
  localparam logic [PS2_TIMER_W-1:0] INHIBIT_LAST = PS2_TIMER_W'(INHIBIT_CYCLES - 1);
  localparam logic [PS2_TIMER_W-1:0] START_LAST   = PS2_TIMER_W'(START_TIMEOUT - 1);
  localparam logic [PS2_TIMER_W-1:0] XFER_LAST    = PS2_TIMER_W'(XFER_TIMEOUT - 1);

  ps2_tx_state_t          r_state;
  logic [9:0]             r_shift;
  logic [3:0]             r_edge_cnt;
  logic [PS2_TIMER_W-1:0] r_timer;
  logic                   r_busy;
  logic                   r_done;
  logic                   r_error;
  logic                   r_clk_oe;
  logic                   r_dat_oe;

  logic w_clk_sync;
  logic w_clk_fall;
  logic w_dat_sync;
  logic w_dat_fall;
  logic w_unused;

  ps2_edge_sync u_clk_sync (
    .clk    (CLOCK_50),
    .rst_n  (resetn),
    .i_async(bus.ps2_clk_in),
    .o_sync (w_clk_sync),
    .o_fall (w_clk_fall)
  );

  ps2_edge_sync u_dat_sync (
    .clk    (CLOCK_50),
    .rst_n  (resetn),
    .i_async(bus.ps2_dat_in),
    .o_sync (w_dat_sync),
    .o_fall (w_dat_fall)
  );

  // Only the receive path needs the CLK level and DAT edge.
  assign w_unused = w_clk_sync ^ w_dat_fall;

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      r_state    <= S_IDLE;
      r_shift    <= '0;
      r_edge_cnt <= '0;
      r_timer    <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
      r_clk_oe   <= 1'b0;
      r_dat_oe   <= 1'b0;
    end else begin
      r_timer <= r_timer + PS2_TIMER_W'(1);
      r_done  <= 1'b0;
      r_error <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          r_timer <= '0;
          if (bus.cmd_send) begin
            r_shift  <= ps2_frame(bus.cmd_data);
            r_busy   <= 1'b1;
            r_clk_oe <= 1'b1;
            r_state  <= S_INHIBIT;
          end
        end
        S_INHIBIT: begin
          if (r_timer == INHIBIT_LAST) begin
            r_dat_oe <= 1'b1;
            r_timer  <= '0;
            r_state  <= S_REQ;
          end
        end
        S_REQ: begin
          r_clk_oe <= 1'b0;
          r_timer  <= '0;
          r_state  <= S_WAIT_CLK;
        end
        S_WAIT_CLK: begin
          if (w_clk_fall) begin
            r_dat_oe   <= ~r_shift[0];
            r_shift    <= r_shift >> 1;
            r_edge_cnt <= 4'd1;
            r_timer    <= '0;
            r_state    <= S_XFER;
          end else if (r_timer == START_LAST) begin
            r_error  <= 1'b1;
            r_clk_oe <= 1'b0;
            r_dat_oe <= 1'b0;
            r_timer  <= '0;
            r_state  <= S_ERR;
          end
        end
        S_XFER: begin
          if (w_clk_fall) begin
            r_edge_cnt <= r_edge_cnt + 4'd1;
            // Edge 11 is the device ACK; earlier edges each present the next frame bit.
            if (r_edge_cnt == 4'd10) begin
              r_done   <= ~w_dat_sync;
              r_error  <= w_dat_sync;
              r_clk_oe <= 1'b0;
              r_dat_oe <= 1'b0;
              r_timer  <= '0;
              r_state  <= w_dat_sync ? S_ERR : S_DONE;
            end else begin
              r_dat_oe <= ~r_shift[0];
              r_shift  <= r_shift >> 1;
            end
          end else if (r_timer == XFER_LAST) begin
            r_error  <= 1'b1;
            r_clk_oe <= 1'b0;
            r_dat_oe <= 1'b0;
            r_timer  <= '0;
            r_state  <= S_ERR;
          end
        end
        S_DONE, S_ERR: begin
          r_busy  <= 1'b0;
          r_timer <= '0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.cmd_busy   = r_busy;
  assign bus.cmd_done   = r_done;
  assign bus.cmd_error  = r_error;
  assign bus.ps2_clk_oe = r_clk_oe;
  assign bus.ps2_dat_oe = r_dat_oe;
endmodule
